// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
//   Collects decoded keypad presses into a packed-BCD entry buffer for the
//   LEA key/plaintext loader. Each key press is echoed to the LCD through a
//   req/ack handshake. '*' clears the entry and '#' submits it.
//
// Ports
//   CLK        in   rising-edge clock
//   RST        in   synchronous active-low reset
//   KEY_VALID  in   1-cycle strobe qualifying KEY_CODE
//   KEY_CODE   in   0-9 digit, 10 '*', 11 '#', 12-15 ignored
//   LCD_REQ    out  LCD write request, held until LCD_ACK
//   LCD_DATA   out  ASCII digit or LCD command byte (0 while LCD_REQ=0)
//   LCD_CLR    out  marks LCD_REQ as a clear-display command (LCD_DATA=8'h01)
//   LCD_ACK    in   LCD writer accepted the request
//   OUT_VALID  out  entry available, held until OUT_READY
//   OUT_DATA   out  packed BCD, newest digit in [3:0], unused nibbles 0
//   OUT_COUNT  out  number of valid digits in OUT_DATA
//   OUT_READY  in   consumer accepts the entry
//   BUSY       out  FSM is not in IDLE
//   ERR        out  1-cycle pulse: key dropped/rejected or LCD timeout
module keypad_entry_ctrl #(
  parameter int MAX_DIGITS  = 8,
  parameter int DATA_W      = 32,
  parameter int LCD_TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              KEY_VALID,
  input  logic [3:0]        KEY_CODE,
  output logic              LCD_REQ,
  output logic [7:0]        LCD_DATA,
  output logic              LCD_CLR,
  input  logic              LCD_ACK,
  output logic              OUT_VALID,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [3:0]        OUT_COUNT,
  input  logic              OUT_READY,
  output logic              BUSY,
  output logic              ERR
);

  localparam int TMO_W = (LCD_TIMEOUT < 2) ? 1 : $clog2(LCD_TIMEOUT + 1);
  // The counter starts at 0 when the request goes out, so the request is
  // dropped on the cycle it reaches LCD_TIMEOUT-1, giving LCD_TIMEOUT cycles
  // of LCD_REQ high.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((LCD_TIMEOUT == 0) ? 0 : LCD_TIMEOUT - 1);
  localparam logic [3:0]       CNT_MAX  = 4'(MAX_DIGITS);
  localparam logic [3:0]       KEY_STAR = 4'd10;
  localparam logic [3:0]       KEY_HASH = 4'd11;
  localparam logic [7:0]       LCD_CMD_CLEAR = 8'h01;

  typedef enum logic [1:0] {IDLE, LCD_WAIT, SUBMIT} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  entry_q, entry_d;
  logic [3:0]         count_q, count_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               lcd_req_q, lcd_req_d;
  logic [7:0]         lcd_data_q, lcd_data_d;
  logic               lcd_clr_q, lcd_clr_d;
  logic               out_valid_q, out_valid_d;
  logic               err_q, err_d;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      entry_q     <= '0;
      count_q     <= '0;
      tmo_q       <= '0;
      lcd_req_q   <= 1'b0;
      lcd_data_q  <= '0;
      lcd_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      count_q     <= count_d;
      tmo_q       <= tmo_d;
      lcd_req_q   <= lcd_req_d;
      lcd_data_q  <= lcd_data_d;
      lcd_clr_q   <= lcd_clr_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    count_d     = count_q;
    tmo_d       = tmo_q;
    lcd_req_d   = lcd_req_q;
    lcd_data_d  = lcd_data_q;
    lcd_clr_d   = lcd_clr_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (KEY_VALID) begin
          if (KEY_CODE <= 4'd9) begin
            if (count_q < CNT_MAX) begin
              entry_d    = {entry_q[DATA_W-5:0], KEY_CODE};
              count_d    = count_q + 4'd1;
              lcd_req_d  = 1'b1;
              lcd_data_d = 8'h30 + {4'h0, KEY_CODE};
              lcd_clr_d  = 1'b0;
              tmo_d      = '0;
              state_d    = LCD_WAIT;
            end else begin
              err_d = 1'b1;
            end
          end else if (KEY_CODE == KEY_STAR) begin
            entry_d    = '0;
            count_d    = '0;
            lcd_req_d  = 1'b1;
            lcd_data_d = LCD_CMD_CLEAR;
            lcd_clr_d  = 1'b1;
            tmo_d      = '0;
            state_d    = LCD_WAIT;
          end else if (KEY_CODE == KEY_HASH) begin
            if (count_q == 4'd0) begin
              err_d = 1'b1;
            end else begin
              out_valid_d = 1'b1;
              state_d     = SUBMIT;
            end
          end
          // codes 12-15 fall through silently
        end
      end

      LCD_WAIT: begin
        // Keys arriving mid-handshake are dropped; the handshake is unaffected.
        err_d = KEY_VALID;
        if (LCD_ACK) begin
          lcd_req_d  = 1'b0;
          lcd_data_d = '0;
          lcd_clr_d  = 1'b0;
          state_d    = IDLE;
        end else if (LCD_TIMEOUT != 0) begin
          if (tmo_q == TMO_LAST) begin
            // Give up on the LCD; the buffer update already made stays.
            lcd_req_d  = 1'b0;
            lcd_data_d = '0;
            lcd_clr_d  = 1'b0;
            err_d      = 1'b1;
            state_d    = IDLE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end

      SUBMIT: begin
        err_d = KEY_VALID;
        if (OUT_READY) begin
          // Entry consumed: empty the buffer and wipe the display.
          out_valid_d = 1'b0;
          entry_d     = '0;
          count_d     = '0;
          lcd_req_d   = 1'b1;
          lcd_data_d  = LCD_CMD_CLEAR;
          lcd_clr_d   = 1'b1;
          tmo_d       = '0;
          state_d     = LCD_WAIT;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign LCD_REQ   = lcd_req_q;
  assign LCD_DATA  = lcd_data_q;
  assign LCD_CLR   = lcd_clr_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = entry_q;
  assign OUT_COUNT = count_q;
  assign BUSY      = (state_q != IDLE);
  assign ERR       = err_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl. LCD writes and submitted entries are
// predicted into queues as keys are driven and popped when the DUT raises
// LCD_REQ / OUT_VALID.
module tb_keypad_entry_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        KEY_VALID = 1'b0;
  logic [3:0]  KEY_CODE = '0;
  logic        LCD_REQ;
  logic [7:0]  LCD_DATA;
  logic        LCD_CLR;
  logic        LCD_ACK = 1'b0;
  logic        OUT_VALID;
  logic [31:0] OUT_DATA;
  logic [3:0]  OUT_COUNT;
  logic        OUT_READY = 1'b0;
  logic        BUSY;
  logic        ERR;

  int errors = 0;
  int checks = 0;

  logic [8:0]  lcd_exp[$];   // {clr, data}
  logic [35:0] out_exp[$];   // {count, data}
  logic        prev_req = 1'b0;
  logic        prev_ov  = 1'b0;

  keypad_entry_ctrl #(.MAX_DIGITS(8), .DATA_W(32), .LCD_TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE),
    .LCD_REQ(LCD_REQ), .LCD_DATA(LCD_DATA), .LCD_CLR(LCD_CLR), .LCD_ACK(LCD_ACK),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_COUNT(OUT_COUNT),
    .OUT_READY(OUT_READY), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: runs once per cycle, just after the edge.
  task automatic monitor();
    logic [8:0]  le;
    logic [35:0] oe;
    if (LCD_REQ === 1'b1 && !prev_req) begin
      if (lcd_exp.size() == 0) begin
        check("lcd_unexpected_req", {27'd0, LCD_CLR, LCD_DATA}, 36'h1ff);
      end else begin
        le = lcd_exp.pop_front();
        check("lcd_write", {27'd0, LCD_CLR, LCD_DATA}, {27'd0, le});
      end
    end
    if (LCD_REQ === 1'b0) check("lcd_data_idle_zero", {28'd0, LCD_DATA}, 36'd0);
    if (OUT_VALID === 1'b1 && !prev_ov) begin
      if (out_exp.size() == 0) begin
        check("out_unexpected_valid", {OUT_COUNT, OUT_DATA}, 36'hfffffffff);
      end else begin
        oe = out_exp.pop_front();
        check("out_entry", {OUT_COUNT, OUT_DATA}, oe);
      end
    end
    prev_req = (LCD_REQ === 1'b1);
    prev_ov  = (OUT_VALID === 1'b1);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    monitor();
  endtask

  task automatic press(input logic [3:0] code);
    KEY_VALID = 1'b1;
    KEY_CODE  = code;
    tick();
    KEY_VALID = 1'b0;
    KEY_CODE  = '0;
  endtask

  // Hold off the ack for n cycles, then accept; request must fall at once.
  task automatic ack_after(input int n);
    repeat (n) tick();
    LCD_ACK = 1'b1;
    tick();
    LCD_ACK = 1'b0;
    check("ack_req_low", {35'd0, LCD_REQ}, 36'd0);
    check("ack_busy_low", {35'd0, BUSY}, 36'd0);
  endtask

  task automatic push_digit(input logic [3:0] d);
    lcd_exp.push_back({1'b0, 8'h30 + {4'h0, d}});
  endtask

  task automatic push_clear();
    lcd_exp.push_back({1'b1, 8'h01});
  endtask

  initial begin
    // 1. reset, then reset again with a request pending
    tick();
    tick();
    check("rst_outputs", {LCD_REQ, LCD_CLR, OUT_VALID, BUSY, ERR, LCD_DATA, OUT_COUNT, 16'd0},
          36'd0);
    check("rst_out_data", {4'd0, OUT_DATA}, 36'd0);
    RST = 1'b1;
    tick();
    push_digit(4'd7);
    press(4'd7);
    check("pending_req", {35'd0, LCD_REQ}, 36'd1);
    RST = 1'b0;
    tick();
    check("midrst_outputs", {LCD_REQ, LCD_CLR, OUT_VALID, BUSY, ERR, LCD_DATA, OUT_COUNT, 16'd0},
          36'd0);
    check("midrst_out_data", {4'd0, OUT_DATA}, 36'd0);
    RST = 1'b1;
    tick();

    // 2. keys 1,2,3 then '#', then accept
    for (int d = 1; d <= 3; d++) begin
      push_digit(4'(d));
      press(4'(d));
      check("digit_busy", {35'd0, BUSY}, 36'd1);
      ack_after(2);
    end
    out_exp.push_back({4'd3, 32'h00000123});
    press(4'd11);
    check("submit_busy", {35'd0, BUSY}, 36'd1);
    tick();
    tick();
    check("submit_hold", {OUT_VALID, 3'd0, OUT_DATA}, {1'b1, 3'd0, 32'h00000123});
    push_clear();
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    check("accept_ov_low", {35'd0, OUT_VALID}, 36'd0);
    check("accept_count0", {32'd0, OUT_COUNT}, 36'd0);
    ack_after(1);

    // 3. nine digits with MAX_DIGITS=8
    for (int d = 0; d < 8; d++) begin
      push_digit(4'(d));
      press(4'(d));
      ack_after(0);
    end
    check("full_buffer", {OUT_COUNT, OUT_DATA}, {4'd8, 32'h01234567});
    press(4'd8);
    check("overflow_err", {ERR, LCD_REQ, BUSY}, {1'b1, 1'b0, 1'b0});
    tick();
    check("overflow_err_pulse", {35'd0, ERR}, 36'd0);
    check("overflow_unchanged", {OUT_COUNT, OUT_DATA}, {4'd8, 32'h01234567});
    push_clear();
    press(4'd10);
    check("star_clears", {OUT_COUNT, OUT_DATA}, 36'd0);
    ack_after(0);

    // 4. 5, '*', '#', plus an ignored code
    push_digit(4'd5);
    press(4'd5);
    ack_after(1);
    check("five_buffered", {OUT_COUNT, OUT_DATA}, {4'd1, 32'h5});
    push_clear();
    press(4'd10);
    check("star_count0", {32'd0, OUT_COUNT}, 36'd0);
    ack_after(1);
    press(4'd11);
    check("hash_empty_err", {ERR, OUT_VALID, BUSY}, {1'b1, 1'b0, 1'b0});
    tick();
    press(4'd12);
    check("ignored_code", {ERR, LCD_REQ, BUSY}, 3'b000);

    // 5. key in LCD_WAIT coinciding with ack; key in SUBMIT
    push_digit(4'd9);
    press(4'd9);
    tick();
    KEY_VALID = 1'b1;
    KEY_CODE  = 4'd4;
    LCD_ACK   = 1'b1;
    tick();
    KEY_VALID = 1'b0;
    LCD_ACK   = 1'b0;
    check("wait_key_dropped", {ERR, LCD_REQ, BUSY}, {1'b1, 1'b0, 1'b0});
    check("wait_key_not_buf", {OUT_COUNT, OUT_DATA}, {4'd1, 32'h9});
    out_exp.push_back({4'd1, 32'h9});
    press(4'd11);
    press(4'd3);
    check("submit_key_dropped", {ERR, OUT_VALID}, 2'b11);
    check("submit_key_not_buf", {OUT_COUNT, OUT_DATA}, {4'd1, 32'h9});
    push_clear();
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    ack_after(0);

    // 6. LCD timeout (LCD_TIMEOUT=4)
    push_digit(4'd6);
    press(4'd6);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("tmo_req_held", {ERR, LCD_REQ}, 2'b01);
    end
    tick();
    check("tmo_drop", {ERR, LCD_REQ, BUSY}, {1'b1, 1'b0, 1'b0});
    check("tmo_digit_kept", {OUT_COUNT, OUT_DATA}, {4'd1, 32'h6});
    tick();
    check("tmo_err_pulse", {35'd0, ERR}, 36'd0);

    check("lcd_queue_drained", 36'(lcd_exp.size()), 36'd0);
    check("out_queue_drained", 36'(out_exp.size()), 36'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
